// File: rtl/regs_module.sv
// regs_module: host-facing TPM register block.
// Byte-wide register file with locality arbitration, a shared interrupt
// vector/enable/status set and a level-sensitive write/read handshake on a
// shared bidirectional data bus.
//
// Handshake semantics (both directions are level based, one transfer per
// assertion):
//   write: host drives data_io and raises data_wr; the first rising edge that
//          sees data_wr=1 with wr_done=0 performs the write and raises wr_done.
//          wr_done follows data_wr from then on, so holding data_wr longer
//          never repeats the write; dropping data_wr clears wr_done next edge.
//   read:  host raises data_req; the first rising edge that sees data_req=1
//          with data_rd=0 captures the addressed byte, drives it on data_io and
//          raises data_rd. Value and data_rd stay frozen until data_req drops,
//          after which data_rd clears and data_io is released on the next edge.
module regs_module #(
    parameter logic [31:0] DID_VID  = 32'h0001_1A2B,
    parameter logic [31:0] INTF_CAP = 32'h0000_0015
) (
    input  logic        clk_i,
    input  logic        lreset_n,
    inout  wire  [7:0]  data_io,
    input  logic [15:0] addr_i,
    input  logic        data_wr,
    output logic        wr_done,
    input  logic        data_req,
    output logic        data_rd,
    output logic [3:0]  irq_num,
    output logic        interrupt
);

    // Register byte offsets that accept writes.
    localparam logic [11:0] OFF_ACCESS   = 12'h000;
    localparam logic [11:0] OFF_INT_EN0  = 12'h008;
    localparam logic [11:0] OFF_INT_EN3  = 12'h00B;
    localparam logic [11:0] OFF_INT_VEC  = 12'h00C;
    localparam logic [11:0] OFF_INT_STS0 = 12'h010;

    // Locality ownership: valid flag plus owning locality number.
    logic       act_vld_q, act_vld_d;
    logic [2:0] act_loc_q, act_loc_d;

    // Shared interrupt registers; enable/status keep only bits 7,2,1,0 as [3:0].
    logic [3:0] int_vec_q, int_vec_d;
    logic       int_gbl_q, int_gbl_d;
    logic [3:0] int_en_q,  int_en_d;
    logic [3:0] int_sts_q, int_sts_d;

    // Handshake and output registers.
    logic       wr_done_q, wr_done_d;
    logic       data_rd_q, data_rd_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [3:0] irq_num_q, irq_num_d;
    logic       irq_q,     irq_d;

    // Address decode.
    logic        loc_ok;
    logic        loc_active;
    logic [11:0] off;
    logic [7:0]  wdata;
    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [7:0]  access_byte;
    logic [31:0] int_en_word;
    logic [31:0] int_sts_word;

    assign off        = addr_i[11:0];
    assign loc_ok     = (addr_i[15:12] <= 4'd4);
    assign loc_active = loc_ok && act_vld_q && (act_loc_q == addr_i[14:12]);
    assign wdata      = data_io;
    assign wr_fire    = data_wr && !wr_done_q;
    assign rd_fire    = data_req && !data_rd_q;

    assign access_byte  = {1'b1, 1'b0, loc_active, 3'b000, 1'b0, 1'b1};
    assign int_en_word  = {int_gbl_q, 23'd0, int_en_q[3], 4'd0, int_en_q[2:0]};
    assign int_sts_word = {24'd0, int_sts_q[3], 4'd0, int_sts_q[2:0]};

    // Read mux: pick the 32-bit word, then the addressed byte (little-endian).
    always_comb begin
        rd_word = 32'hFFFF_FFFF;
        case (off[11:2])
            10'h000: rd_word = {24'hFF_FFFF, access_byte};
            10'h002: rd_word = int_en_word;
            10'h003: rd_word = {24'hFF_FFFF, 4'd0, int_vec_q};
            10'h004: rd_word = int_sts_word;
            10'h005: rd_word = INTF_CAP;
            10'h006: rd_word = 32'h0000_0000;
            10'h00C: rd_word = 32'h0000_0000;
            10'h3C0: rd_word = DID_VID;
            10'h3C1: rd_word = 32'hFFFF_FF00;
            default: rd_word = 32'hFFFF_FFFF;
        endcase
        rd_byte = loc_ok ? rd_word[{off[1:0], 3'b000} +: 8] : 8'hFF;
    end

    // Next-state logic for register writes, locality arbitration and handshakes.
    always_comb begin
        act_vld_d = act_vld_q;
        act_loc_d = act_loc_q;
        int_vec_d = int_vec_q;
        int_gbl_d = int_gbl_q;
        int_en_d  = int_en_q;
        int_sts_d = int_sts_q;
        rd_data_d = rd_data_q;
        wr_done_d = data_wr;
        data_rd_d = data_req;

        if (wr_fire && loc_ok) begin
            case (off)
                OFF_ACCESS: begin
                    // Request wins only when the bus is free; relinquish only
                    // from the owner. The two conditions cannot both hold.
                    if (wdata[1] && !act_vld_q) begin
                        act_vld_d = 1'b1;
                        act_loc_d = addr_i[14:12];
                    end else if (wdata[5] && loc_active) begin
                        act_vld_d = 1'b0;
                    end
                end
                OFF_INT_EN0: if (loc_active) int_en_d = {wdata[7], wdata[2:0]};
                OFF_INT_EN3: if (loc_active) int_gbl_d = wdata[7];
                OFF_INT_VEC: if (loc_active) int_vec_d = wdata[3:0];
                OFF_INT_STS0: begin
                    if (loc_active) int_sts_d = int_sts_q & ~{wdata[7], wdata[2:0]};
                end
                default: ;
            endcase
        end

        if (rd_fire) begin
            rd_data_d = rd_byte;
        end

        irq_num_d = int_vec_q;
        irq_d     = int_gbl_q & (|(int_sts_q & int_en_q));
    end

    // State registers; reset aborts any handshake and frees the locality.
    always_ff @(posedge clk_i or negedge lreset_n) begin
        if (!lreset_n) begin
            act_vld_q <= 1'b0;
            act_loc_q <= 3'd0;
            int_vec_q <= 4'd0;
            int_gbl_q <= 1'b0;
            int_en_q  <= 4'd0;
            int_sts_q <= 4'd0;
            wr_done_q <= 1'b0;
            data_rd_q <= 1'b0;
            rd_data_q <= 8'd0;
            irq_num_q <= 4'd0;
            irq_q     <= 1'b0;
        end else begin
            act_vld_q <= act_vld_d;
            act_loc_q <= act_loc_d;
            int_vec_q <= int_vec_d;
            int_gbl_q <= int_gbl_d;
            int_en_q  <= int_en_d;
            int_sts_q <= int_sts_d;
            wr_done_q <= wr_done_d;
            data_rd_q <= data_rd_d;
            rd_data_q <= rd_data_d;
            irq_num_q <= irq_num_d;
            irq_q     <= irq_d;
        end
    end

    // The bus is driven only while read data is valid and never during a write.
    assign data_io   = (data_rd_q && !data_wr) ? rd_data_q : 8'hzz;
    assign wr_done   = wr_done_q;
    assign data_rd   = data_rd_q;
    assign irq_num   = irq_num_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_regs_module.sv
// tb_regs_module: directed bench for regs_module with hand-computed expectations.
module tb_regs_module;

  logic        clk_i;
  logic        lreset_n;
  wire  [7:0]  data_io;
  logic [15:0] addr_i;
  logic        data_wr;
  logic        wr_done;
  logic        data_req;
  logic        data_rd;
  logic [3:0]  irq_num;
  logic        interrupt;

  logic [7:0]  drv_data;
  logic        drv_en;
  logic [7:0]  exp_q[$];

  int n_checks;
  int n_pass;
  int n_fail;

  assign data_io = drv_en ? drv_data : 8'hzz;

  regs_module #(
    .DID_VID (32'h0001_1A2B),
    .INTF_CAP(32'h0000_0015)
  ) dut (
    .clk_i    (clk_i),
    .lreset_n (lreset_n),
    .data_io  (data_io),
    .addr_i   (addr_i),
    .data_wr  (data_wr),
    .wr_done  (wr_done),
    .data_req (data_req),
    .data_rd  (data_rd),
    .irq_num  (irq_num),
    .interrupt(interrupt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Bus released: a weak bench drive of 5A must read back unchanged.
  task automatic check_released(input string tag);
    drv_data = 8'h5A;
    drv_en   = 1'b1;
    #1;
    check(tag, {24'd0, data_io}, 32'h5A);
    drv_en = 1'b0;
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    int n;
    @(negedge clk_i);
    addr_i   = a;
    drv_data = d;
    drv_en   = 1'b1;
    data_wr  = 1'b1;
    n = 0;
    while (!wr_done && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check($sformatf("wr_done_set_%h", a), {31'd0, wr_done}, 32'd1);
    repeat (hold) @(negedge clk_i);
    data_wr = 1'b0;
    drv_en  = 1'b0;
    @(negedge clk_i);
    check($sformatf("wr_done_clr_%h", a), {31'd0, wr_done}, 32'd0);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp, input int hold);
    int n;
    logic [7:0] e;
    exp_q.push_back(exp);
    @(negedge clk_i);
    addr_i   = a;
    data_req = 1'b1;
    n = 0;
    while (!data_rd && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check($sformatf("data_rd_set_%h", a), {31'd0, data_rd}, 32'd1);
    e = exp_q.pop_front();
    check($sformatf("rd_%h", a), {24'd0, data_io}, {24'd0, e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check($sformatf("rd_hold_%h", a), {24'd0, data_io}, {24'd0, e});
    end
    data_req = 1'b0;
    @(negedge clk_i);
    check($sformatf("data_rd_clr_%h", a), {31'd0, data_rd}, 32'd0);
    check_released($sformatf("rd_release_%h", a));
  endtask

  task automatic check_irq(input string tag, input logic [3:0] exp);
    @(negedge clk_i);
    check(tag, {28'd0, irq_num}, {28'd0, exp});
  endtask

  // Register contents with no locality owned and all shared registers zero.
  function automatic logic [7:0] idle_value(input logic [11:0] off);
    case (off)
      12'h000: return 8'h81;
      12'h008, 12'h009, 12'h00A, 12'h00B: return 8'h00;
      12'h00C: return 8'h00;
      12'h010, 12'h011, 12'h012, 12'h013: return 8'h00;
      12'h014: return 8'h15;
      12'h015, 12'h016, 12'h017: return 8'h00;
      12'h018, 12'h019, 12'h01A, 12'h01B: return 8'h00;
      12'h030, 12'h031, 12'h032, 12'h033: return 8'h00;
      12'hF00: return 8'h2B;
      12'hF01: return 8'h1A;
      12'hF02: return 8'h01;
      12'hF03: return 8'h00;
      12'hF04: return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_fifo(input logic [11:0] off);
    return (off >= 12'h024 && off <= 12'h027) || (off >= 12'h080 && off <= 12'h083);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [11:0] offs[$];
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    lreset_n = 1'b0;
    addr_i   = 16'h0000;
    data_wr  = 1'b0;
    data_req = 1'b0;
    drv_data = 8'h00;
    drv_en   = 1'b0;

    repeat (3) @(negedge clk_i);
    check("rst_wr_done", {31'd0, wr_done}, 32'd0);
    check("rst_data_rd", {31'd0, data_rd}, 32'd0);
    check("rst_irq_num", {28'd0, irq_num}, 32'd0);
    check("rst_interrupt", {31'd0, interrupt}, 32'd0);
    check_released("rst_release");
    lreset_n = 1'b1;
    repeat (2) @(negedge clk_i);

    // Identification registers, immediate and held reads.
    bus_read(16'h0F00, 8'h2B, 0);
    bus_read(16'h0F01, 8'h1A, 0);
    bus_read(16'h0F02, 8'h01, 0);
    bus_read(16'h0F03, 8'h00, 0);
    bus_read(16'h0F00, 8'h2B, 10);
    bus_read(16'h0F01, 8'h1A, 10);
    bus_read(16'h0F02, 8'h01, 10);
    bus_read(16'h0F03, 8'h00, 10);
    bus_read(16'h0F04, 8'h00, 0);
    bus_read(16'h0F05, 8'hFF, 0);
    bus_read(16'h0014, 8'h15, 0);

    // Sweep: read, write zero everywhere except FIFOs, re-read.
    for (int i = 0; i < 256; i++) offs.push_back(12'(i));
    for (int i = 0; i < 16; i++) offs.push_back(12'hF00 + 12'(i));
    foreach (offs[i]) bus_read({4'h0, offs[i]}, idle_value(offs[i]), 0);
    foreach (offs[i]) if (!is_fifo(offs[i])) bus_write({4'h0, offs[i]}, 8'h00, 0);
    foreach (offs[i]) bus_read({4'h0, offs[i]}, idle_value(offs[i]), 0);

    // Locality 0 takes ownership; others cannot steal or release it.
    bus_write(16'h0000, 8'h02, 0);
    bus_read(16'h0000, 8'hA1, 0);
    bus_read(16'h1000, 8'h81, 0);
    bus_write(16'h1000, 8'h02, 0);
    bus_read(16'h1000, 8'h81, 0);
    bus_write(16'h1000, 8'h20, 0);
    bus_read(16'h0000, 8'hA1, 0);

    // Interrupt vector from the owner, normal and long write hold.
    bus_write(16'h000C, 8'h05, 0);
    check_irq("irq_vec_05", 4'h5);
    bus_read(16'h000C, 8'h05, 0);
    bus_write(16'h000C, 8'hFA, 0);
    check_irq("irq_vec_fa", 4'hA);
    bus_read(16'h000C, 8'h0A, 0);
    bus_write(16'h000C, 8'h05, 10);
    check_irq("irq_vec_05_hold", 4'h5);
    bus_read(16'h000C, 8'h05, 0);
    bus_write(16'h000C, 8'hFA, 10);
    check_irq("irq_vec_fa_hold", 4'hA);
    bus_read(16'h300C, 8'h0A, 0);

    // Interrupt enable / status: only implemented bits stick, status W1C stays 0.
    bus_write(16'h0008, 8'hFF, 0);
    bus_write(16'h0009, 8'hFF, 0);
    bus_write(16'h000B, 8'hFF, 0);
    bus_read(16'h0008, 8'h87, 0);
    bus_read(16'h0009, 8'h00, 0);
    bus_read(16'h100B, 8'h80, 0);
    bus_write(16'h0010, 8'hFF, 0);
    bus_read(16'h0010, 8'h00, 0);
    check("interrupt_no_status", {31'd0, interrupt}, 32'd0);
    bus_write(16'h0008, 8'h00, 0);
    bus_write(16'h000B, 8'h00, 0);
    bus_read(16'h0008, 8'h00, 0);
    bus_read(16'h000B, 8'h00, 0);

    // Ownership moves to locality 2; locality 0 writes are ignored.
    bus_write(16'h000C, 8'h00, 0);
    check_irq("irq_vec_clear", 4'h0);
    bus_write(16'h0000, 8'h20, 0);
    bus_read(16'h0000, 8'h81, 0);
    bus_write(16'h2000, 8'h02, 0);
    bus_read(16'h2000, 8'hA1, 0);
    bus_read(16'h0000, 8'h81, 0);
    bus_write(16'h000C, 8'h05, 0);
    check_irq("irq_nonowner_05", 4'h0);
    bus_read(16'h000C, 8'h00, 0);
    bus_write(16'h000C, 8'hFA, 0);
    check_irq("irq_nonowner_fa", 4'h0);
    bus_read(16'h000C, 8'h00, 0);
    bus_write(16'h0008, 8'hFF, 0);
    bus_read(16'h0008, 8'h00, 0);

    // No owner: vector writes ignored, every locality reads not-active.
    bus_write(16'h2000, 8'h20, 0);
    bus_write(16'h000C, 8'h05, 0);
    check_irq("irq_noowner_05", 4'h0);
    bus_read(16'h000C, 8'h00, 0);
    bus_write(16'h000C, 8'hFA, 0);
    check_irq("irq_noowner_fa", 4'h0);
    bus_read(16'h000C, 8'h00, 0);
    for (int l = 0; l < 5; l++) bus_read({4'(l), 12'h000}, 8'h81, 0);
    bus_read(16'h5000, 8'hFF, 0);
    bus_read(16'hF00C, 8'hFF, 0);
    bus_write(16'h5000, 8'h02, 0);
    bus_read(16'h0000, 8'h81, 0);

    // Request+relinquish in one long-held write: exactly one write happens.
    bus_write(16'h1000, 8'h22, 10);
    bus_read(16'h1000, 8'hA1, 0);
    bus_write(16'h1000, 8'h20, 0);
    bus_read(16'h1000, 8'h81, 0);

    // Reset in the middle of a read.
    bus_write(16'h3000, 8'h02, 0);
    bus_write(16'h300C, 8'h07, 0);
    bus_write(16'h3008, 8'h87, 0);
    check_irq("irq_before_reset", 4'h7);
    @(negedge clk_i);
    addr_i   = 16'h0F00;
    data_req = 1'b1;
    n = 0;
    while (!data_rd && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("midrd_data_rd", {31'd0, data_rd}, 32'd1);
    check("midrd_data", {24'd0, data_io}, 32'h2B);
    lreset_n = 1'b0;
    #1;
    check("midrd_rst_data_rd", {31'd0, data_rd}, 32'd0);
    check("midrd_rst_irq", {28'd0, irq_num}, 32'd0);
    check("midrd_rst_interrupt", {31'd0, interrupt}, 32'd0);
    check_released("midrd_rst_release");
    data_req = 1'b0;
    @(negedge clk_i);
    lreset_n = 1'b1;
    bus_read(16'h3000, 8'h81, 0);
    bus_read(16'h300C, 8'h00, 0);
    bus_read(16'h3008, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
